adc_readout_sequencer: RTL and testbench

//  Downstream of the acquisition core. After a capture completes (data_ready), walks the circular

---
 rtl/adc_readout_sequencer.sv | 163 ++++++++++++++++
 tb/tb_adc_readout_sequencer.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_readout_sequencer.sv
// Streams captured samples from the circular sample RAM to the host transmitter,
// channel-major, one byte per valid/ready handshake, starting at the first pre-trigger sample.
module adc_readout_sequencer #(
    parameter int RAM_WIDTH  = 10,
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start_read,
    input  logic                 data_ready,
    input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
    input  logic [RAM_WIDTH-1:0] triggerpoint,
    input  logic [RAM_WIDTH:0]   num_samples,
    input  logic [3:0]           chan_mask,
    output logic                 rden,
    output logic [RAM_WIDTH-1:0] rdaddress,
    input  logic [7:0]           ram_q1,
    input  logic [7:0]           ram_q2,
    input  logic [7:0]           ram_q3,
    input  logic [7:0]           ram_q4,
    output logic [7:0]           tx_data,
    output logic                 tx_valid,
    input  logic                 tx_ready,
    output logic                 busy,
    output logic                 done
);

    localparam int LW = (RD_LATENCY < 2) ? 1 : $clog2(RD_LATENCY);
    localparam logic [LW-1:0]      LAT_LAST = LW'(RD_LATENCY - 1);
    localparam logic [RAM_WIDTH:0] DEPTH    = {1'b1, {RAM_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        IDLE,
        WAIT_RDY,
        ADDR,
        WAIT_RAM,
        SEND,
        DONE
    } state_t;

    state_t               state, state_next;
    logic [RAM_WIDTH-1:0] start_addr;
    logic [RAM_WIDTH:0]   n_lat;
    logic [3:0]           mask_lat;
    logic [3:0]           left;
    logic [1:0]           ch;
    logic [RAM_WIDTH:0]   k;
    logic [LW-1:0]        lat_cnt;

    logic [RAM_WIDTH:0]   k_inc;
    logic                 last_sample;
    logic                 lat_done;
    logic                 start_ok;
    logic [1:0]           first_ch;
    logic [1:0]           next_ch;
    logic [7:0]           q_sel;

    function automatic logic [1:0] low_bit(input logic [3:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int unsigned i = 4; i > 0; i--) begin
            if (v[i-1]) idx = 2'(i - 1);
        end
        return idx;
    endfunction

    assign k_inc       = k + 1'b1;
    assign last_sample = (k_inc == n_lat);
    assign lat_done    = (lat_cnt == LAT_LAST);
    assign start_ok    = (n_lat != '0) && (mask_lat != '0);
    assign first_ch    = low_bit(mask_lat);
    assign next_ch     = low_bit(left);

    always_comb begin
        q_sel = ram_q1;
        case (ch)
            2'd1:    q_sel = ram_q2;
            2'd2:    q_sel = ram_q3;
            2'd3:    q_sel = ram_q4;
            default: q_sel = ram_q1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start_read) state_next = WAIT_RDY;
            WAIT_RDY: if (data_ready) state_next = start_ok ? ADDR : DONE;
            ADDR:     state_next = WAIT_RAM;
            WAIT_RAM: if (lat_done) state_next = SEND;
            SEND: begin
                if (tx_ready) begin
                    if (last_sample && left == '0) state_next = DONE;
                    else                           state_next = ADDR;
                end
            end
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    assign rden     = (state == ADDR);
    assign tx_valid = (state == SEND);
    assign busy     = (state != IDLE) && (state != DONE);
    assign done     = (state == DONE);

    // rdaddress is loaded on entry to ADDR so it is already valid during the rden cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            start_addr <= '0;
            n_lat      <= '0;
            mask_lat   <= '0;
            left       <= '0;
            ch         <= '0;
            k          <= '0;
            lat_cnt    <= '0;
            rdaddress  <= '0;
            tx_data    <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start_read) begin
                        start_addr <= wraddress_triggerpoint - triggerpoint;
                        n_lat      <= (num_samples > DEPTH) ? DEPTH : num_samples;
                        mask_lat   <= chan_mask;
                    end
                end
                WAIT_RDY: begin
                    if (data_ready && start_ok) begin
                        ch        <= first_ch;
                        left      <= mask_lat & ~(4'b0001 << first_ch);
                        k         <= '0;
                        rdaddress <= start_addr;
                    end
                end
                ADDR: lat_cnt <= '0;
                WAIT_RAM: begin
                    lat_cnt <= lat_cnt + 1'b1;
                    if (lat_done) tx_data <= q_sel;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (last_sample) begin
                            if (left != '0) begin
                                ch        <= next_ch;
                                left      <= left & ~(4'b0001 << next_ch);
                                k         <= '0;
                                rdaddress <= start_addr;
                            end
                        end else begin
                            k         <= k_inc;
                            rdaddress <= start_addr + k_inc[RAM_WIDTH-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_readout_sequencer.sv
// Directed bench for adc_readout_sequencer: a RAM model with 2-cycle read latency,
// an expected address/byte stream built per run, and a negedge monitor.
module tb_adc_readout_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_read;
    logic       data_ready;
    logic [9:0] wraddress_triggerpoint;
    logic [9:0] triggerpoint;
    logic [10:0] num_samples;
    logic [3:0] chan_mask;
    logic       rden;
    logic [9:0] rdaddress;
    logic [7:0] ram_q1, ram_q2, ram_q3, ram_q4;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    adc_readout_sequencer #(.RAM_WIDTH(10), .RD_LATENCY(2)) dut (
        .clk(clk), .reset(reset), .start_read(start_read), .data_ready(data_ready),
        .wraddress_triggerpoint(wraddress_triggerpoint), .triggerpoint(triggerpoint),
        .num_samples(num_samples), .chan_mask(chan_mask), .rden(rden), .rdaddress(rdaddress),
        .ram_q1(ram_q1), .ram_q2(ram_q2), .ram_q3(ram_q3), .ram_q4(ram_q4),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem(input int c, input logic [9:0] a);
        int v;
        v = int'(a) * 13 + c * 71 + int'(a >> 3);
        return v[7:0];
    endfunction

    // RAM read port: address registered with rden, data valid two edges later
    logic       p0v = 1'b0, p1v = 1'b0;
    logic [9:0] p0a = '0, p1a = '0;
    always @(posedge clk) begin
        p0v <= rden;
        p0a <= rdaddress;
        p1v <= p0v;
        p1a <= p0a;
    end
    assign ram_q1 = p1v ? mem(1, p1a) : 8'h5A;
    assign ram_q2 = p1v ? mem(2, p1a) : 8'h5A;
    assign ram_q3 = p1v ? mem(3, p1a) : 8'h5A;
    assign ram_q4 = p1v ? mem(4, p1a) : 8'h5A;

    int   ncyc = 0;
    logic rst_q = 1'b0;
    always @(posedge clk) begin
        ncyc  <= ncyc + 1;
        rst_q <= reset;
    end

    int tot = 0;
    int bad = 0;

    logic [9:0] exp_addr[$];
    logic [7:0] exp_bytes[$];
    logic [9:0] addr_log[$];
    logic [7:0] byte_log[$];
    int         hs_edges[$];
    int         first_rden = -1;
    int         first_valid = -1;
    int         stalls = 0;
    int         done_cnt = 0;
    int         acc_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tot++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every cycle compares the DUT against the expected streams and protocol rules
    initial begin
        logic       prev_hold;
        logic       prev_done;
        logic [7:0] prev_data;
        prev_hold = 1'b0;
        prev_done = 1'b0;
        prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_q && prev_hold) begin
                check("hold_valid", tx_valid, 1);
                check("hold_data", tx_data, prev_data);
            end
            if (rden) begin
                addr_log.push_back(rdaddress);
                if (first_rden < 0) first_rden = ncyc + 1;
                check("rden_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) check("rdaddress", rdaddress, exp_addr.pop_front());
            end
            if (tx_valid && first_valid < 0) first_valid = ncyc + 1;
            if (tx_valid && !tx_ready) stalls++;
            if (tx_valid && tx_ready) begin
                byte_log.push_back(tx_data);
                hs_edges.push_back(ncyc);
                check("byte_expected", exp_bytes.size() != 0, 1);
                if (exp_bytes.size() != 0) check("tx_data", tx_data, exp_bytes.pop_front());
            end
            if (done) begin
                done_cnt++;
                check("busy_in_done", busy, 0);
                check("done_one_cycle", prev_done, 0);
            end
            prev_done = done;
            prev_hold = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic start_run(input logic [9:0] wtp, input logic [9:0] tp, input logic [10:0] ns,
                             input logic [3:0] m, input logic dr);
        logic [9:0] sv;
        int         n;
        @(posedge clk); #1;
        sv = wtp - tp;
        n  = (ns > 11'd1024) ? 1024 : int'(ns);
        exp_addr.delete();
        exp_bytes.delete();
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                for (int k = 0; k < n; k++) begin
                    logic [9:0] a;
                    a = sv + 10'(k);
                    exp_addr.push_back(a);
                    exp_bytes.push_back(mem(c + 1, a));
                end
            end
        end
        addr_log.delete();
        byte_log.delete();
        hs_edges.delete();
        first_rden  = -1;
        first_valid = -1;
        stalls      = 0;
        done_cnt    = 0;
        wraddress_triggerpoint = wtp;
        triggerpoint           = tp;
        num_samples            = ns;
        chan_mask              = m;
        data_ready             = dr;
        start_read             = 1'b1;
        @(posedge clk); #1;
        start_read = 1'b0;
        acc_edge   = ncyc;
        check("busy_after_accept", busy, 1);
    endtask

    task automatic finish_run(input int nbytes, input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 6000 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done_seen"}, seen, 1);
        @(negedge clk);
        check({name, "_busy_after"}, busy, 0);
        check({name, "_bytes"}, byte_log.size(), nbytes);
        check({name, "_bytes_left"}, exp_bytes.size(), 0);
        check({name, "_addr_left"}, exp_addr.size(), 0);
        check({name, "_done_pulses"}, done_cnt, 1);
        @(posedge clk); #1;
        data_ready = 1'b0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        reset = 1'b1;
        start_read = 1'b0;
        data_ready = 1'b0;
        wraddress_triggerpoint = '0;
        triggerpoint = '0;
        num_samples = '0;
        chan_mask = '0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_rden", rden, 0);
        check("rst_rdaddress", rdaddress, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // basic single-channel readout, with latency and per-byte pacing
        start_run(10'd100, 10'd40, 11'd4, 4'b0001, 1'b1);
        finish_run(4, "t1");
        check("t1_rden_delay", first_rden - acc_edge, 2);
        check("t1_valid_delay", first_valid - acc_edge, 5);
        check("t1_byte_period", hs_edges[1] - hs_edges[0], 4);
        check("t1_addr0", addr_log[0], 60);
        check("t1_addr3", addr_log[3], 63);
        check("t1_byte0", byte_log[0], 90);

        // start address wraps below zero
        start_run(10'd5, 10'd8, 11'd6, 4'b0001, 1'b1);
        finish_run(6, "t2");
        check("t2_addr0", addr_log[0], 1021);
        check("t2_addr2", addr_log[2], 1023);
        check("t2_addr3", addr_log[3], 0);
        check("t2_addr5", addr_log[5], 2);

        // two channels, channel-major order
        start_run(10'd10, 10'd0, 11'd3, 4'b1010, 1'b1);
        finish_run(6, "t3");
        check("t3_addr3", addr_log[3], 10);
        check("t3_byte0", byte_log[0], 17);
        check("t3_byte3", byte_log[3], 159);

        // transmitter stall of 7 cycles on the second byte
        start_run(10'd300, 10'd0, 11'd5, 4'b0100, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (tx_valid && hs_edges.size() == 1) found = 1'b1;
        end
        check("t4_stall_point", found, 1);
        tx_ready = 1'b0;
        repeat (7) @(posedge clk);
        #1 tx_ready = 1'b1;
        finish_run(5, "t4");
        check("t4_stall_cycles", stalls, 7);

        // empty mask; a second start_read while busy must be ignored
        start_run(10'd0, 10'd0, 11'd5, 4'b0000, 1'b0);
        chan_mask   = 4'b0001;
        num_samples = 11'd3;
        start_read  = 1'b1;
        @(posedge clk); #1;
        start_read = 1'b0;
        check("t5_busy_waiting", busy, 1);
        repeat (3) @(posedge clk);
        #1 data_ready = 1'b1;
        finish_run(0, "t5a");
        check("t5a_no_reads", addr_log.size(), 0);

        // zero samples
        start_run(10'd0, 10'd0, 11'd0, 4'b1111, 1'b1);
        finish_run(0, "t5b");

        // oversized request clamps to the full RAM depth, wrapping once
        start_run(10'd0, 10'd1, 11'd1500, 4'b1000, 1'b1);
        finish_run(1024, "tmax");
        check("tmax_addr0", addr_log[0], 1023);
        check("tmax_addr1", addr_log[1], 0);

        // reset while a byte is waiting for the transmitter
        tx_ready = 1'b0;
        start_run(10'd50, 10'd0, 11'd4, 4'b0001, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk); #1;
            if (tx_valid) found = 1'b1;
        end
        check("t6_in_send", found, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        data_ready = 1'b0;
        @(negedge clk);
        check("t6_rden", rden, 0);
        check("t6_rdaddress", rdaddress, 0);
        check("t6_tx_valid", tx_valid, 0);
        check("t6_tx_data", tx_data, 0);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        exp_addr.delete();
        exp_bytes.delete();
        tx_ready = 1'b1;
        start_run(10'd200, 10'd7, 11'd3, 4'b0011, 1'b1);
        finish_run(6, "t6b");
        check("t6b_addr0", addr_log[0], 193);
        check("t6b_addr3", addr_log[3], 193);

        $display("test done: total=%0d bad=%0d", tot, bad);
        $finish;
    end

endmodule
